// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MULT/DIV sequencer state encoding, op selects and exception codes.
package cpu_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LAUNCH   = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_WRITE    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_EXC_DIV0 = 3'd5;
  localparam logic [2:0] S_EXC_TO   = 3'd6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 40;
  localparam int unsigned DEFAULT_CNT_W   = 6;

  // Codes consumed by the exception-handling block.
  typedef enum logic [1:0] {
    EXC_CODE_NONE    = 2'd0,
    EXC_CODE_DIV0    = 2'd1,
    EXC_CODE_TIMEOUT = 2'd2
  } exc_code_t;

endpackage

// File: rtl/multdiv_sequencer_wait_timer.sv
// WAIT-cycle counter with synchronous clear, enable and a terminal flag at TIMEOUT-1.
module multdiv_sequencer_wait_timer #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             terminal_c
);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign terminal_c = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences the iterative multiplier/divider for MULT/DIV and drives HI/LO writes and exceptions.
module multdiv_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic             div_sel,
  input  logic             divisor_zero,
  input  logic             mult_done,
  input  logic             div_done,
  output logic             mult_start,
  output logic             div_start,
  output logic             hilo_src,
  output logic             hi_we,
  output logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             div0_exc,
  output logic             timeout_exc,
  output logic [CNT_W-1:0] last_cycles
);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic             op_q;
  logic             op_d;
  logic             sel_done;
  logic             tmr_clear;
  logic             tmr_en;
  logic             tmr_tc;
  logic [CNT_W-1:0] cnt;

  multdiv_sequencer_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .Clock      (Clock),
    .Reset      (Reset),
    .clear      (tmr_clear),
    .enable     (tmr_en),
    .cnt        (cnt),
    .terminal_c (tmr_tc)
  );

  // Next-state logic; only the selected unit's done is honoured, and done beats timeout.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    sel_done  = (op_q == OP_DIV) ? div_done : mult_done;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = div_sel;
          state_d = (div_sel && divisor_zero) ? S_EXC_DIV0 : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tmr_clear = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        tmr_en = 1'b1;
        if (sel_done) begin
          state_d = S_WRITE;
        end else if (tmr_tc) begin
          state_d = S_EXC_TO;
        end
      end
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Moore outputs registered from the next state so they line up with state_q.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mult_start  <= 1'b0;
      div_start   <= 1'b0;
      hi_we       <= 1'b0;
      lo_we       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div0_exc    <= 1'b0;
      timeout_exc <= 1'b0;
      last_cycles <= '0;
    end else begin
      mult_start  <= (state_d == S_LAUNCH) && (op_d == OP_MULT);
      div_start   <= (state_d == S_LAUNCH) && (op_d == OP_DIV);
      hi_we       <= (state_d == S_WRITE);
      lo_we       <= (state_d == S_WRITE);
      busy        <= (state_d != S_IDLE);
      done        <= (state_d == S_DONE);
      div0_exc    <= (state_d == S_EXC_DIV0);
      timeout_exc <= (state_d == S_EXC_TO);
      if ((state_q == S_WAIT) && sel_done) begin
        last_cycles <= cnt + CNT_W'(1);
      end
    end
  end

  assign hilo_src = op_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized self-checking bench for multdiv_sequencer using a transaction-timeline reference model.
module tb_multdiv_sequencer;

  localparam int unsigned TIMEOUT = 40;
  localparam int unsigned CNT_W   = 6;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             start = 1'b0;
  logic             div_sel = 1'b0;
  logic             divisor_zero = 1'b0;
  logic             mult_done = 1'b0;
  logic             div_done = 1'b0;
  logic             mult_start;
  logic             div_start;
  logic             hilo_src;
  logic             hi_we;
  logic             lo_we;
  logic             busy;
  logic             done;
  logic             div0_exc;
  logic             timeout_exc;
  logic [CNT_W-1:0] last_cycles;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_last = '0;

  multdiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .start        (start),
    .div_sel      (div_sel),
    .divisor_zero (divisor_zero),
    .mult_done    (mult_done),
    .div_done     (div_done),
    .mult_start   (mult_start),
    .div_start    (div_start),
    .hilo_src     (hilo_src),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .busy         (busy),
    .done         (done),
    .div0_exc     (div0_exc),
    .timeout_exc  (timeout_exc),
    .last_cycles  (last_cycles)
  );

  always #5 Clock = ~Clock;

  // Output vector: {mult_start, div_start, hilo_src, hi_we, lo_we, busy, done, div0_exc, timeout_exc}
  task automatic check_vec(input string tag, input int c, input logic [8:0] exp_v);
    logic [8:0] obs;
    obs = {mult_start, div_start, hilo_src, hi_we, lo_we, busy, done, div0_exc, timeout_exc};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cycle %0d outputs: got %b want %b", tag, c, obs, exp_v);
    end
  endtask

  task automatic check_last(input string tag, input int c);
    checks++;
    assert (last_cycles === exp_last) else begin
      errors++;
      $error("FAIL %s cycle %0d last_cycles: got %0d want %0d", tag, c, last_cycles, exp_last);
    end
  endtask

  // One transaction; entered just after an edge in IDLE. j = WAIT index of the selected done, -1 = never.
  task automatic run_op(input string tag, input logic op, input logic dz, input int j,
                        input bit level, input bit noise);
    bit div0;
    bit got;
    int w;
    int last_c;
    logic sd;
    logic [8:0] exp_v;
    div0   = op && dz;
    got    = (j >= 0);
    w      = got ? j + 1 : int'(TIMEOUT);
    last_c = div0 ? 2 : (got ? 4 + w : 3 + w);
    start = 1'b1; div_sel = op; divisor_zero = dz; mult_done = 1'b0; div_done = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      @(posedge Clock); #1;
      exp_v    = '0;
      exp_v[6] = op;
      exp_v[3] = (c < last_c);
      if (div0) begin
        exp_v[1] = (c == 1);
      end else begin
        exp_v[8] = (c == 1) && !op;
        exp_v[7] = (c == 1) && op;
        exp_v[5] = got && (c == 2 + w);
        exp_v[4] = got && (c == 2 + w);
        exp_v[2] = got && (c == 3 + w);
        exp_v[0] = !got && (c == 2 + w);
      end
      check_vec(tag, c, exp_v);
      if (!div0 && got && c == 2 + w) exp_last = CNT_W'(j + 1);
      else check_last(tag, c);
      if (c == last_c) begin
        start = 1'b0; mult_done = 1'b0; div_done = 1'b0;
      end else begin
        sd = level ? (got && c >= 2 + j) : (got && c == 2 + j);
        if (noise && c == 1) sd = sd | 1'($urandom_range(0, 1));
        if (div0 && noise) sd = 1'($urandom_range(0, 1));
        if (op) begin
          div_done  = sd;
          mult_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end else begin
          mult_done = sd;
          div_done  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        div_sel      = noise ? 1'($urandom_range(0, 1)) : op;
        divisor_zero = noise ? 1'($urandom_range(0, 1)) : dz;
      end
    end
  endtask

  initial begin
    int r;
    int jj;
    repeat (2) @(posedge Clock);
    #1;
    check_vec("reset", 0, 9'b0);
    check_last("reset", 0);
    Reset = 1'b0;

    run_op("mult", 1'b0, 1'b0, 8, 1'b0, 1'b0);
    run_op("div0", 1'b1, 1'b1, 0, 1'b0, 1'b0);
    run_op("timeout", 1'b1, 1'b0, -1, 1'b0, 1'b0);
    run_op("wrong_unit", 1'b1, 1'b0, 3, 1'b0, 1'b1);
    run_op("collision", 1'b1, 1'b0, int'(TIMEOUT) - 1, 1'b0, 1'b0);
    run_op("mult_dz", 1'b0, 1'b1, 5, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      r  = int'($urandom_range(0, 9));
      jj = (r == 0) ? -1 : ((r == 1) ? int'(TIMEOUT) - 1 : int'($urandom_range(0, 15)));
      run_op("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), jj,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset during WAIT with the divider claiming done: nothing may be written afterwards.
    start = 1'b1; div_sel = 1'b1; divisor_zero = 1'b0;
    @(posedge Clock); #1;
    start = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check_vec("pre_reset_busy", 0, 9'b0_0100_1000);
    div_done = 1'b1;
    Reset = 1'b1;
    #1;
    exp_last = '0;
    check_vec("reset_async", 0, 9'b0);
    check_last("reset_async", 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge Clock); #1;
      check_vec("post_reset", c, 9'b0);
    end
    div_done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Sequences the iterative multiplier and divider for MULT/DIV and writes their results into the HI/LO registers.
- Sits between the main multicycle Control FSM and the two arithmetic units.
- Control issues one start pulse with the operation select. It then waits on busy/done while this block drives the unit start pulses, HI/LO write enables and result mux select.
- Also raises the divide-by-zero and unit-timeout exceptions.

Parameters:
TIMEOUT, 40, max WAIT cycles before a unit is declared hung (must be ≥2)
CNT_W, 6, counter width; 2**CNT_W must exceed TIMEOUT

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
start  in  1  request from Control; sampled only in IDLE
div_sel  in  1  0 = MULT, 1 = DIV; sampled with start
divisor_zero  in  1  B operand == 0; sampled with start
mult_done  in  1  multiplier result valid (level or pulse)
div_done  in  1  divider result valid (level or pulse)
mult_start  out  1  one-cycle start pulse to multiplier
div_start  out  1  one-cycle start pulse to divider
hilo_src  out  1  HI/LO input mux: 0 = multiplier, 1 = divider; equals latched op
hi_we  out  1  HI register write enable
lo_we  out  1  LO register write enable
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse: HI/LO updated
div0_exc  out  1  one-cycle pulse: DIV with zero divisor
timeout_exc  out  1  one-cycle pulse: unit did not finish
last_cycles  out  CNT_W  WAIT-cycle count of last completed op

Behaviour:
- Reset (async, any state, mid-operation included):
  - state = IDLE; op_q = 0; cnt = 0; last_cycles = 0.
  - All outputs 0. No partial HI/LO write may occur after reset asserts.
- States: IDLE, LAUNCH, WAIT, WRITE, DONE, EXC_DIV0, EXC_TO. Outputs are registered/decoded from state only (Moore).
- IDLE:
  - start=1 latches op_q = div_sel.
  - If div_sel=1 and divisor_zero=1 → EXC_DIV0; else → LAUNCH.
  - start=0 → stay.
- LAUNCH:
  - mult_start = ~op_q, div_start = op_q, for exactly one cycle.
  - cnt cleared to 0. → WAIT.
- WAIT:
  - cnt increments each cycle.
  - Only the done of the selected unit is honoured; the other unit's done is ignored.
  - Selected done=1 → WRITE.
  - Else if cnt == TIMEOUT-1 → EXC_TO.
  - done and timeout in the same cycle: done wins.
- WRITE:
  - hi_we = lo_we = 1 for one cycle; hilo_src = op_q.
  - last_cycles = cnt+1 (WAIT cycles spent, including the done cycle). → DONE.
- DONE: done = 1 for one cycle. → IDLE.
- EXC_DIV0: div0_exc = 1 for one cycle; no unit start, no HI/LO write. → IDLE.
- EXC_TO: timeout_exc = 1 for one cycle; no HI/LO write; last_cycles unchanged. → IDLE.
- hilo_src equals op_q in every state (stable before and during WRITE).
- Latency, with start seen in IDLE at edge 0:
  - LAUNCH at cycle 1, WAIT from cycle 2.
  - Selected done seen in WAIT at cycle k gives WRITE at k+1, DONE at k+2, IDLE at k+3.
- start outside IDLE is ignored, including in the DONE cycle. Control must re-issue start after busy falls.
- divisor_zero is ignored for MULT.
- A unit done asserted during LAUNCH is not sampled.
- cnt saturates logic is unnecessary: TIMEOUT bounds it.

Decomposition:
- Shared package (cpu_pkg): state encoding localparams (3-bit: IDLE=0, LAUNCH=1, WAIT=2, WRITE=3, DONE=4, EXC_DIV0=5, EXC_TO=6), OP_MULT=0 / OP_DIV=1 constants, default TIMEOUT.
- Exception codes for div0/timeout go in the same package for the future exception-handling block.
- One natural sub-module: wait_timer (CNT_W counter with clear, enable and terminal-count flag at TIMEOUT-1). Everything else stays in the top FSM.

Test Plan:
1. Reset mid-WAIT: assert Reset while busy=1 → same cycle all outputs 0, busy=0; no hi_we pulse afterwards.
2. MULT: start=1, div_sel=0 at cycle 0.
   - Expect mult_start=1 at cycle 1 only, div_start=0 throughout.
   - mult_done=1 at cycle 10 → hi_we=lo_we=1 at cycle 11 with hilo_src=0, done=1 at cycle 12, busy=0 at cycle 13, last_cycles=9.
3. DIV by zero: start=1, div_sel=1, divisor_zero=1 → div0_exc=1 at cycle 1 only; no div_start, hi_we or lo_we; busy=0 at cycle 2.
4. Timeout: DIV with divisor_zero=0, div_done held 0, TIMEOUT=40 → timeout_exc pulse after 40 WAIT cycles (cycle 42); no writes; last_cycles unchanged from prior op.
5. Wrong-unit done and ignored start:
   - During a DIV, pulse mult_done and re-assert start → no state change.
   - div_done at cycle 5 → WRITE at cycle 6 with hilo_src=1.
6. Done/timeout collision: div_done=1 exactly on the cnt==TIMEOUT-1 cycle → WRITE and done occur; timeout_exc stays 0.
